tsp_tour_eval: RTL and testbench

Parametrised tour-length evaluator for the TSP solver datapath. Given city coordinate arrays and a candidate visiting order, it walks the closed tour one edge per cycle through a two-stage distance/accumulate pipeline and reports the total length. It also keeps a best-so-far record, so the solver and bench can judge candidate paths without software post-processing. It generalises the fixed 64-city, 8-bit, Manhattan-only evaluation to arbitrary city count, coordinate width and a selectable metric.

---
 rtl/tsp_pkg.sv | 20 ++
 rtl/tsp_edge_dist.sv | 41 ++++
 rtl/tsp_tour_eval.sv | 166 ++++++++++++++++
 tb/tb_tsp_tour_eval.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tsp_pkg.sv
// Shared types and width helper for the TSP tour-length evaluator.
package tsp_pkg;

  typedef enum logic {
    MANHATTAN = 1'b0,
    CHEBYSHEV = 1'b1
  } metric_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Widest closed-tour length: N edges of at most 2*(2^COORD_W-1) each.
  function automatic int len_w(input int coord_w, input int n_city);
    return coord_w + 1 + $clog2(n_city);
  endfunction

endpackage

// File: rtl/tsp_edge_dist.sv
// Registered edge-length stage: |dx|,|dy| reduced by Manhattan sum or Chebyshev max.
module tsp_edge_dist
  import tsp_pkg::*;
#(
  parameter int COORD_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  input  logic               metric,
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  output logic               valid_q,
  output logic [COORD_W:0]   dist_q
);

  logic [COORD_W-1:0] dx, dy;
  logic [COORD_W:0]   dist_d;
  logic               valid_d;

  always_comb begin
    dx      = (ax >= bx) ? (ax - bx) : (bx - ax);
    dy      = (ay >= by) ? (ay - by) : (by - ay);
    valid_d = valid_in;
    if (metric == CHEBYSHEV) dist_d = (dx >= dy) ? {1'b0, dx} : {1'b0, dy};
    else                     dist_d = {1'b0, dx} + {1'b0, dy};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      dist_q  <= '0;
    end else begin
      valid_q <= valid_d;
      dist_q  <= dist_d;
    end
  end

endmodule

// File: rtl/tsp_tour_eval.sv
// Closed-tour length evaluator: one edge per cycle through distance stage and
// accumulator, with a best-so-far record updated on each completed tour.
module tsp_tour_eval
  import tsp_pkg::*;
#(
  parameter int N_CITY  = 64,
  parameter int COORD_W = 8,
  parameter int IDX_W   = $clog2(N_CITY),
  parameter int LEN_W   = len_w(COORD_W, N_CITY)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      metric,
  input  logic [N_CITY*COORD_W-1:0] xs,
  input  logic [N_CITY*COORD_W-1:0] ys,
  input  logic [N_CITY*IDX_W-1:0]   path,
  input  logic                      clear_best,
  output logic                      busy,
  output logic                      done,
  output logic [LEN_W-1:0]          tour_len,
  output logic                      improved,
  output logic [LEN_W-1:0]          best_len,
  output logic                      best_valid
);

  state_e                   state_q, state_d;
  metric_e                  metric_q, metric_d;
  logic [IDX_W-1:0]         cnt_q, cnt_d;
  logic [N_CITY*IDX_W-1:0]  path_q, path_d;
  logic [LEN_W-1:0]         acc_q, acc_d;
  logic [LEN_W-1:0]         tour_len_q, tour_len_d;
  logic [LEN_W-1:0]         best_len_q, best_len_d;
  logic                     done_q, done_d;
  logic                     improved_q, improved_d;
  logic                     best_valid_q, best_valid_d;
  logic                     issue;
  logic [IDX_W-1:0]         idx_a, idx_b;
  logic [COORD_W-1:0]       ax, ay, bx, by;
  logic                     s1_valid;
  logic [COORD_W:0]         s1_dist;

  // Edge i runs from path[i] to path[(i+1) mod N], closing the tour.
  always_comb begin
    idx_a = '0;
    idx_b = '0;
    for (int k = 0; k < N_CITY; k++) begin
      if (cnt_q == IDX_W'(k)) begin
        idx_a = path_q[k*IDX_W +: IDX_W];
        idx_b = path_q[((k + 1) % N_CITY)*IDX_W +: IDX_W];
      end
    end
  end

  // Indices with no matching city fall through to city 0.
  always_comb begin
    ax = xs[0 +: COORD_W];
    ay = ys[0 +: COORD_W];
    bx = xs[0 +: COORD_W];
    by = ys[0 +: COORD_W];
    for (int k = 0; k < N_CITY; k++) begin
      if (idx_a == IDX_W'(k)) begin
        ax = xs[k*COORD_W +: COORD_W];
        ay = ys[k*COORD_W +: COORD_W];
      end
      if (idx_b == IDX_W'(k)) begin
        bx = xs[k*COORD_W +: COORD_W];
        by = ys[k*COORD_W +: COORD_W];
      end
    end
  end

  tsp_edge_dist #(.COORD_W(COORD_W)) u_dist (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (issue),
    .metric   (metric_q),
    .ax       (ax),
    .ay       (ay),
    .bx       (bx),
    .by       (by),
    .valid_q  (s1_valid),
    .dist_q   (s1_dist)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    path_d     = path_q;
    metric_d   = metric_q;
    acc_d      = acc_q;
    tour_len_d = tour_len_q;
    issue      = 1'b0;
    done_d     = 1'b0;
    if (s1_valid) acc_d = acc_q + LEN_W'(s1_dist);
    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          state_d  = RUN;
          cnt_d    = '0;
          path_d   = path;
          metric_d = metric_e'(metric);
          acc_d    = '0;
        end
      end
      RUN: begin
        issue = 1'b1;
        if (cnt_q == IDX_W'(N_CITY - 1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        // Last edge has left stage 1 once its valid drops; the sum is final.
        if (!s1_valid) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          tour_len_d = acc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    improved_d   = done_d && !clear_best && (!best_valid_q || (acc_q < best_len_q));
    best_len_d   = improved_d ? acc_q : best_len_q;
    best_valid_d = clear_best ? 1'b0 : (improved_d ? 1'b1 : best_valid_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      metric_q     <= MANHATTAN;
      cnt_q        <= '0;
      path_q       <= '0;
      acc_q        <= '0;
      tour_len_q   <= '0;
      best_len_q   <= '0;
      done_q       <= 1'b0;
      improved_q   <= 1'b0;
      best_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      metric_q     <= metric_d;
      cnt_q        <= cnt_d;
      path_q       <= path_d;
      acc_q        <= acc_d;
      tour_len_q   <= tour_len_d;
      best_len_q   <= best_len_d;
      done_q       <= done_d;
      improved_q   <= improved_d;
      best_valid_q <= best_valid_d;
    end
  end

  assign busy       = (state_q != IDLE) || done_q;
  assign done       = done_q;
  assign tour_len   = tour_len_q;
  assign improved   = improved_q;
  assign best_len   = best_len_q;
  assign best_valid = best_valid_q;

endmodule

// File: tb/tb_tsp_tour_eval.sv
// Directed checks of tsp_tour_eval on a 4-city square and a 64-city alternating layout.
module tb_tsp_tour_eval;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // 4-city instance
  logic        s4_start, s4_metric, s4_clr;
  logic [31:0] s4_xs, s4_ys;
  logic [7:0]  s4_path;
  logic        b4_busy, b4_done, b4_imp, b4_bv;
  logic [10:0] b4_len, b4_best;

  // 64-city instance; 7-bit indices so out-of-range entries can be expressed
  logic         s64_start, s64_metric, s64_clr;
  logic [511:0] s64_xs, s64_ys;
  logic [447:0] s64_path;
  logic         b64_busy, b64_done, b64_imp, b64_bv;
  logic [14:0]  b64_len, b64_best;

  tsp_tour_eval #(.N_CITY(4), .COORD_W(8), .IDX_W(2), .LEN_W(11)) u4 (
    .clk(clk), .rst_n(rst_n), .start(s4_start), .metric(s4_metric),
    .xs(s4_xs), .ys(s4_ys), .path(s4_path), .clear_best(s4_clr),
    .busy(b4_busy), .done(b4_done), .tour_len(b4_len), .improved(b4_imp),
    .best_len(b4_best), .best_valid(b4_bv)
  );

  tsp_tour_eval #(.N_CITY(64), .COORD_W(8), .IDX_W(7), .LEN_W(15)) u64 (
    .clk(clk), .rst_n(rst_n), .start(s64_start), .metric(s64_metric),
    .xs(s64_xs), .ys(s64_ys), .path(s64_path), .clear_best(s64_clr),
    .busy(b64_busy), .done(b64_done), .tour_len(b64_len), .improved(b64_imp),
    .best_len(b64_best), .best_valid(b64_bv)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start a run on u4; optionally pulse start or clear_best after a given edge count.
  task automatic run4(input logic [7:0] p, input logic m, input int poke, input int clr_at,
                      output int lat, output logic bsy);
    if (b4_done) @(posedge clk);
    @(negedge clk);
    s4_path = p; s4_metric = m; s4_start = 1'b1;
    @(posedge clk); #1;
    s4_start = 1'b0;
    bsy = b4_busy;
    lat = 0;
    while (b4_done !== 1'b1 && lat < 40) begin
      s4_start = (poke != 0) && (lat == poke);
      s4_clr   = (clr_at != 0) && (lat == clr_at);
      @(posedge clk); #1;
      lat++;
    end
    s4_start = 1'b0;
    s4_clr   = 1'b0;
  endtask

  task automatic run64(output int lat);
    if (b64_done) @(posedge clk);
    @(negedge clk);
    s64_metric = 1'b0; s64_start = 1'b1;
    @(posedge clk); #1;
    s64_start = 1'b0;
    lat = 0;
    while (b64_done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int   lat;
    logic bsy;
    logic seen;

    rst_n = 1'b0;
    s4_start = 0; s4_metric = 0; s4_clr = 0; s4_path = '0;
    s4_xs = {8'd0, 8'd10, 8'd10, 8'd0};
    s4_ys = {8'd10, 8'd10, 8'd0, 8'd0};
    s64_start = 0; s64_metric = 0; s64_clr = 0;
    for (int k = 0; k < 64; k++) begin
      s64_xs[k*8 +: 8]   = (k % 2 == 1) ? 8'd255 : 8'd0;
      s64_ys[k*8 +: 8]   = (k % 2 == 1) ? 8'd255 : 8'd0;
      s64_path[k*7 +: 7] = 7'(k);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", b4_busy, 0);
    check("rst_done", b4_done, 0);
    check("rst_improved", b4_imp, 0);
    check("rst_tour_len", b4_len, 0);
    check("rst_best_len", b4_best, 0);
    check("rst_best_valid", b4_bv, 0);
    check("rst_busy64", b64_busy, 0);
    rst_n = 1'b1;

    // Square, in order, Manhattan: 4 edges of 10
    run4(8'hE4, 1'b0, 0, 0, lat, bsy);
    check("sq_busy_after_start", bsy, 1);
    check("sq_latency", lat, 6);
    check("sq_len", b4_len, 40);
    check("sq_improved", b4_imp, 1);
    check("sq_best_len", b4_best, 40);
    check("sq_best_valid", b4_bv, 1);
    check("sq_busy_in_done", b4_busy, 1);

    // Path 0,2,1,3 Manhattan: 20+10+20+10
    run4(8'hD8, 1'b0, 0, 0, lat, bsy);
    check("x_man_len", b4_len, 60);
    check("x_man_improved", b4_imp, 0);
    check("x_man_best", b4_best, 40);

    // Same path Chebyshev: 10 each, ties best
    run4(8'hD8, 1'b1, 0, 0, lat, bsy);
    check("x_cheb_len", b4_len, 40);
    check("x_cheb_improved_tie", b4_imp, 0);
    check("x_cheb_best", b4_best, 40);

    // start during the done cycle must be ignored
    s4_start = 1'b1;
    @(posedge clk); #1;
    s4_start = 1'b0;
    check("start_in_done_ignored", b4_busy, 0);

    // Back-to-back start with a stray start mid-run
    run4(8'hE4, 1'b1, 2, 0, lat, bsy);
    check("midstart_latency", lat, 6);
    check("midstart_len", b4_len, 40);
    @(posedge clk); #1;
    check("midstart_no_rerun", b4_busy, 0);

    // Path 0,0,1,1 = 20 would improve; clear_best on the same edge wins
    run4(8'h50, 1'b0, 0, 5, lat, bsy);
    check("clr_len", b4_len, 20);
    check("clr_improved", b4_imp, 0);
    check("clr_best_valid", b4_bv, 0);
    run4(8'h50, 1'b0, 0, 0, lat, bsy);
    check("after_clr_improved", b4_imp, 1);
    check("after_clr_best_valid", b4_bv, 1);
    check("after_clr_best", b4_best, 20);

    // 64 alternating cities: 64 edges of 510
    run64(lat);
    check("n64_latency", lat, 66);
    check("n64_len", b64_len, 32640);
    check("n64_improved", b64_imp, 1);

    // Index 70 reads city 0: edges 4->5 and 5->6 collapse to 0
    s64_path[5*7 +: 7] = 7'd70;
    run64(lat);
    check("n64_oor_len", b64_len, 31620);
    check("n64_oor_best", b64_best, 31620);

    // Reset three edges into a run
    if (b4_done) @(posedge clk);
    @(negedge clk);
    s4_path = 8'hE4; s4_metric = 1'b0; s4_start = 1'b1;
    @(posedge clk); #1;
    s4_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", b4_busy, 0);
    check("abort_best_valid", b4_bv, 0);
    check("abort_tour_len", b4_len, 0);
    check("abort_best_len", b4_best, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (b4_done) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
